// File: rtl/load_use_scoreboard_pkg.sv
// Shared constants and types for the load-use scoreboard: register file shape
// and the issue-latency encodings carried by each tracked write.
package load_use_scoreboard_pkg;

    localparam int REGISTER_COUNT = 32;
    localparam int REG_NUM_W      = 5;
    localparam int MAX_LATENCY    = 3;
    localparam int CW             = $clog2(MAX_LATENCY + 1);

    typedef logic [REG_NUM_W-1:0] reg_num_t;
    typedef logic [CW-1:0]        countdown_t;

    localparam countdown_t LATENCY_EXECUTE       = countdown_t'(0);
    localparam countdown_t LATENCY_MEMORY_ACCESS = countdown_t'(1);
    localparam countdown_t LATENCY_MAX           = countdown_t'(MAX_LATENCY);

endpackage

// File: rtl/load_use_scoreboard_entry.sv
// Scoreboard entry: one countdown of cycles left until a pending register
// write becomes forwardable. A new set overrides the decrement (youngest writer wins).
module load_use_scoreboard_entry
    import load_use_scoreboard_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       freeze,
    input  logic       set,
    input  countdown_t set_value,
    output countdown_t count
);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (!freeze) begin
            if (set) begin
                count <= set_value;
            end else if (count != '0) begin
                count <= count - countdown_t'(1);
            end
        end
    end

endmodule

// File: rtl/load_use_scoreboard.sv
// Decode-side hazard scoreboard: stalls decode while a source register still
// has an in-flight write that has not yet reached a forwarding path.
module load_use_scoreboard
    import load_use_scoreboard_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        freeze,
    input  logic        flush,
    input  logic        issue_valid,
    input  logic        issue_write_enable,
    input  reg_num_t    issue_destination_register_number,
    input  countdown_t  issue_latency,
    input  reg_num_t    register_number_a,
    input  reg_num_t    register_number_b,
    input  logic        register_use_a,
    input  logic        register_use_b,
    output logic        stall,
    output logic        issue_accepted,
    output logic [31:0] stall_count
);

    countdown_t countdown [REGISTER_COUNT];
    logic       pending_a;
    logic       pending_b;
    logic       write_issue;

    // Register 0 is hard-wired zero, so it can never be pending.
    assign countdown[0] = '0;

    assign write_issue = issue_accepted & issue_write_enable;

    for (genvar r = 1; r < REGISTER_COUNT; r++) begin : g_entry
        load_use_scoreboard_entry u_entry (
            .clock     (clock),
            .reset     (reset),
            .freeze    (freeze),
            .set       (write_issue && (issue_destination_register_number == reg_num_t'(r))),
            .set_value (issue_latency),
            .count     (countdown[r])
        );
    end

    // No same-cycle bypass: only writes already registered can stall decode.
    assign pending_a = register_use_a && (countdown[register_number_a] != '0);
    assign pending_b = register_use_b && (countdown[register_number_b] != '0);

    assign stall          = ~flush & issue_valid & (pending_a | pending_b);
    assign issue_accepted = issue_valid & ~stall & ~freeze & ~flush;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_count <= '0;
        end else if (stall && !freeze && (stall_count != 32'hFFFF_FFFF)) begin
            stall_count <= stall_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_load_use_scoreboard.sv
// Directed bench for load_use_scoreboard: a table of per-cycle decode inputs
// with hand-computed stall / issue_accepted / stall_count, plus an async-reset sequence.
module tb_load_use_scoreboard;
    import load_use_scoreboard_pkg::*;

    logic        clock;
    logic        reset;
    logic        freeze;
    logic        flush;
    logic        issue_valid;
    logic        issue_write_enable;
    reg_num_t    issue_destination_register_number;
    countdown_t  issue_latency;
    reg_num_t    register_number_a;
    reg_num_t    register_number_b;
    logic        register_use_a;
    logic        register_use_b;
    logic        stall;
    logic        issue_accepted;
    logic [31:0] stall_count;

    int n_vec;
    int n_miss;

    typedef struct {
        logic        frz;
        logic        fl;
        logic        iv;
        logic        we;
        reg_num_t    dst;
        countdown_t  lat;
        reg_num_t    ra;
        logic        ua;
        reg_num_t    rb;
        logic        ub;
        logic        exp_stall;
        logic        exp_acc;
        logic [31:0] exp_cnt;
    } vec_t;

    vec_t vecs[$];

    load_use_scoreboard dut (
        .clock                             (clock),
        .reset                             (reset),
        .freeze                            (freeze),
        .flush                             (flush),
        .issue_valid                       (issue_valid),
        .issue_write_enable                (issue_write_enable),
        .issue_destination_register_number (issue_destination_register_number),
        .issue_latency                     (issue_latency),
        .register_number_a                 (register_number_a),
        .register_number_b                 (register_number_b),
        .register_use_a                    (register_use_a),
        .register_use_b                    (register_use_b),
        .stall                             (stall),
        .issue_accepted                    (issue_accepted),
        .stall_count                       (stall_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic vec_t mk(input logic frz, input logic fl, input logic iv,
                                input logic we, input int dst, input int lat,
                                input int ra, input logic ua, input int rb, input logic ub,
                                input logic es, input logic ea, input int ec);
        vec_t v;
        v.frz = frz; v.fl = fl; v.iv = iv; v.we = we;
        v.dst = reg_num_t'(dst); v.lat = countdown_t'(lat);
        v.ra = reg_num_t'(ra); v.ua = ua; v.rb = reg_num_t'(rb); v.ub = ub;
        v.exp_stall = es; v.exp_acc = ea; v.exp_cnt = 32'(ec);
        return v;
    endfunction

    // Writer with no sources, and a reader on port a only.
    function automatic vec_t wr(input int dst, input int lat, input logic es, input logic ea, input int ec);
        return mk(1'b0, 1'b0, 1'b1, 1'b1, dst, lat, 0, 1'b0, 0, 1'b0, es, ea, ec);
    endfunction

    function automatic vec_t rd(input logic frz, input int ra, input logic es, input logic ea, input int ec);
        return mk(frz, 1'b0, 1'b1, 1'b0, 0, 0, ra, 1'b1, 0, 1'b0, es, ea, ec);
    endfunction

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] required);
        if (actual !== required) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, required, $time);
        end
    endtask

    task automatic drive(input vec_t v);
        freeze = v.frz; flush = v.fl; issue_valid = v.iv; issue_write_enable = v.we;
        issue_destination_register_number = v.dst; issue_latency = v.lat;
        register_number_a = v.ra; register_use_a = v.ua;
        register_number_b = v.rb; register_use_b = v.ub;
    endtask

    task automatic idle();
        drive(mk(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 0));
    endtask

    initial begin
        n_vec  = 0;
        n_miss = 0;
        reset  = 1'b1;
        idle();

        // Basic latency-0 write then reader: never stalls.
        vecs.push_back(wr(5, LATENCY_EXECUTE, 0, 1, 0));
        vecs.push_back(rd(0, 5, 0, 1, 0));
        // Load latency 1 then dependent: exactly one stall cycle.
        vecs.push_back(wr(5, LATENCY_MEMORY_ACCESS, 0, 1, 0));
        vecs.push_back(rd(0, 5, 1, 0, 0));
        vecs.push_back(rd(0, 5, 0, 1, 1));
        // Latency 2 write overridden by a younger latency-0 write to the same register.
        vecs.push_back(wr(5, 2, 0, 1, 1));
        vecs.push_back(wr(5, LATENCY_EXECUTE, 0, 1, 1));
        vecs.push_back(rd(0, 5, 0, 1, 1));
        // Latency 3 to x7, four frozen cycles, then three stall cycles.
        vecs.push_back(wr(7, LATENCY_MAX, 0, 1, 1));
        for (int i = 0; i < 4; i++) vecs.push_back(rd(1, 7, 1, 0, 1));
        vecs.push_back(rd(0, 7, 1, 0, 1));
        vecs.push_back(rd(0, 7, 1, 0, 2));
        vecs.push_back(rd(0, 7, 1, 0, 3));
        vecs.push_back(rd(0, 7, 0, 1, 4));
        // x0 writes are never tracked.
        vecs.push_back(wr(0, 2, 0, 1, 4));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 1, 0, 1, 0, 1, 4));
        // Unused port on a pending register, flush, then port b hit.
        vecs.push_back(wr(6, LATENCY_MAX, 0, 1, 4));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 6, 0, 0, 1, 0, 1, 4));
        vecs.push_back(mk(0, 1, 1, 1, 6, 0, 6, 1, 0, 0, 0, 0, 4));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 6, 1, 1, 0, 4));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 6, 1, 6, 1, 0, 1, 5));
        // Both sources on the same pending register: single stall stream.
        vecs.push_back(wr(8, 2, 0, 1, 5));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 8, 1, 8, 1, 1, 0, 5));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 8, 1, 8, 1, 1, 0, 6));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 8, 1, 8, 1, 0, 1, 7));
        // Dependent one cycle later: latency 3 gives 2 stalls.
        vecs.push_back(wr(10, LATENCY_MAX, 0, 1, 7));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 10, 1, 0, 0, 0, 0, 7));
        vecs.push_back(rd(0, 10, 1, 0, 7));
        vecs.push_back(rd(0, 10, 1, 0, 8));
        vecs.push_back(rd(0, 10, 0, 1, 9));

        // Reset state.
        #3;
        issue_valid = 1'b1;
        #1;
        n_vec++;
        check("reset_stall", 32'(stall), 32'd0);
        check("reset_accepted", 32'(issue_accepted), 32'd1);
        check("reset_stall_count", stall_count, 32'd0);
        #8 reset = 1'b0;
        @(posedge clock);
        #1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i]);
            #3;
            n_vec++;
            check($sformatf("v%0d_stall", i), 32'(stall), 32'(vecs[i].exp_stall));
            check($sformatf("v%0d_accepted", i), 32'(issue_accepted), 32'(vecs[i].exp_acc));
            check($sformatf("v%0d_stall_count", i), stall_count, vecs[i].exp_cnt);
            @(posedge clock);
            #1;
        end

        // Async reset while x9 is pending with countdown 2.
        drive(wr(9, 2, 0, 1, 0));
        @(posedge clock);
        #1;
        drive(rd(0, 9, 1, 0, 0));
        #2;
        n_vec++;
        check("pre_reset_stall", 32'(stall), 32'd1);
        reset = 1'b1;
        #1;
        n_vec++;
        check("mid_reset_stall", 32'(stall), 32'd0);
        check("mid_reset_stall_count", stall_count, 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        #2;
        n_vec++;
        check("post_reset_stall", 32'(stall), 32'd0);
        check("post_reset_accepted", 32'(issue_accepted), 32'd1);
        @(posedge clock);
        #1;
        idle();
        #2;
        n_vec++;
        check("post_reset_stall_count", stall_count, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
